xadc_drp_scheduler: RTL and testbench
=====================================

# xadc_drp_scheduler

Sequences and shares the XADC dynamic reconfiguration port (DRP). On every end-of-sequence pulse it runs a scan that reads a programmable list of channel result registers. Between scan transactions it grants single read or write transactions to a host requester, such as the UART/config path. It sits between the `xadc_wiz_0` instance and the acquisition logic and replaces ad-hoc DRP address toggling.

## Interface
Parameters:
- `NUM_CH`, default 2: channels per scan, 1..16.
- `CH_ADDR`, default {7'h03, 7'h00}: packed list of `NUM_CH` × 7-bit DRP addresses. Slot 0 is the LSBs (temp); slot 1 is Vp/Vn.
- `TIMEOUT`, default 64: cycles to wait for `drp_drdy` after `drp_den`, 4..255.

Ports:
- `clk` in 1: DRP/system clock.
- `rst` in 1: reset, synchronous, active-low.
- `eos` in 1: XADC end-of-sequence. Any high cycle requests a scan.
- `drp_daddr` out 7: DRP address.
- `drp_den` out 1: DRP enable, 1-cycle pulse.
- `drp_dwe` out 1: DRP write enable, qualified by `drp_den`.
- `drp_di` out 16: DRP write data.
- `drp_do` in 16: DRP read data.
- `drp_drdy` in 1: DRP data ready.
- `host_req` in 1: host transaction request. Level; hold until ack.
- `host_we` in 1: 1 = write, 0 = read. Stable while `host_req` is high.
- `host_addr` in 7: host DRP address.
- `host_wdata` in 16: host write data.
- `host_ack` out 1: 1-cycle completion pulse.
- `host_rdata` out 16: read data, valid with `host_ack`.
- `host_err` out 1: timeout flag, valid with `host_ack`.
- `smp_valid` out 1: 1-cycle pulse per completed scan slot.
- `smp_idx` out 4: slot index of the sample.
- `smp_data` out 12: `drp_do[15:4]` of the slot.
- `scan_done` out 1: 1-cycle pulse after the last slot.
- `overrun` out 1: 1-cycle pulse when `eos` arrives while a scan is already pending.
- `timeout_err` out 1: 1-cycle pulse when a scan slot times out.

## Operation
- **States:** IDLE, SCAN_ISSUE, SCAN_WAIT, HOST_ISSUE, HOST_WAIT.
- **Scan pending:**
  - `eos` high in any cycle sets `scan_pend`.
  - If `scan_pend` is already set and no scan has started since, `overrun` pulses and the requests coalesce into one scan.
  - `scan_pend` clears when slot 0 is issued.
  - An `eos` arriving during an active scan sets `scan_pend` again, so a new full scan follows.
- **Arbitration (IDLE only, one decision per DRP transaction):**
  - If only the scan or only the host is pending, grant it.
  - If both are pending, grant the requester not granted last. After reset the scan wins.
  - A scan in progress counts as pending for its remaining slots. The host can therefore interleave at most one transaction between consecutive scan slots.
- **SCAN_ISSUE:**
  - Drive `drp_daddr`=`CH_ADDR[slot]`, `drp_dwe`=0, `drp_den`=1 for one cycle.
  - Go to SCAN_WAIT.
- **SCAN_WAIT:**
  - On `drp_drdy`=1: capture `drp_do[15:4]` and return to IDLE. Next cycle, pulse `smp_valid` with `smp_idx`=slot. If slot = `NUM_CH`−1, pulse `scan_done` in the same cycle and reset slot to 0; otherwise increment slot.
  - If `TIMEOUT` cycles pass without `drp_drdy`: pulse `timeout_err`, emit no `smp_valid`, advance the slot as above (`scan_done` still pulses on the last slot), return to IDLE.
- **HOST_ISSUE:** drive `host_addr`, `host_we`, `host_wdata` onto the DRP with `drp_den`=1 for one cycle, then go to HOST_WAIT.
- **HOST_WAIT:**
  - On `drp_drdy`: `host_ack`=1, `host_rdata`=`drp_do` (0 for a write), `host_err`=0.
  - On timeout: `host_ack`=1, `host_rdata`=0, `host_err`=1.
  - Return to IDLE.
  - The host must drop `host_req` the cycle after `host_ack`. The arbiter ignores `host_req` in the cycle of `host_ack`.
- `drp_drdy` in IDLE or ISSUE states is ignored.
- **Reset:**
  - All outputs go to 0; `drp_daddr`=0.
  - State=IDLE, slot=0, `scan_pend`=0, last-grant=host (so the scan wins first).
  - A DRP transaction in flight is abandoned; its late `drp_drdy` is ignored.

## Timing
- All outputs are registered.
- **`eos` to DRP:** `eos` high in cycle 0, with IDLE and no host contention, gives `drp_den` high in cycle 2 with `drp_daddr`=`CH_ADDR[0]`.
- **`drp_drdy` to outputs:** `drp_drdy` in cycle n gives `smp_valid` / `host_ack` in cycle n+1.
- **Back-to-back DRP transactions:** the next `drp_den` comes no earlier than 2 cycles after the previous `drp_drdy`.
- **Timeout:** with `drp_den` in cycle d and no `drp_drdy`, the abort happens at cycle d+`TIMEOUT`. `timeout_err` / `host_err` is visible at d+`TIMEOUT`+1.
- **`drp_drdy` in the timeout cycle:** `drp_drdy` wins and the transaction completes normally.

## Structure
- Package `xadc_pkg` holds:
  - DRP address constants: `ADDR_TEMP`=7'h00, `ADDR_VCCINT`=7'h01, `ADDR_VCCAUX`=7'h02, `ADDR_VPVN`=7'h03, `ADDR_CFG0`=7'h40.
  - DRP width constants (7/16).
  - The state enum.
- Sub-module `drp_watchdog`: loadable down-counter with a start input and an expired pulse, used for both timeout paths.

## Test plan
- **Single scan:** `eos` pulse; DRP model answers after 3 cycles with 16'hABC0, then 16'h1230. Expect:
  - `drp_daddr` 7'h00 then 7'h03.
  - `smp_valid` twice, with `smp_idx` 0/1 and `smp_data` 12'hABC/12'h123.
  - `scan_done` with the second `smp_valid`.
- **Contention:** `host_req` (read 7'h40) raised in the same cycle as `eos`. Expect the DRP order to be slot 0, then host, then slot 1. Expect `host_ack` with `host_rdata`=model value.
- **Overrun:**
  - `eos` high for 3 consecutive cycles gives exactly one scan and one `overrun` pulse.
  - A second `eos` mid-scan gives a full second scan after `scan_done`.
- **Timeout:** model never asserts `drp_drdy` for slot 1. Expect:
  - `timeout_err` at `drp_den`+65 and no `smp_valid` for slot 1.
  - `scan_done` still pulses.
  - A subsequent host write gets `host_err`=1 if it also times out.
- **Reset:** assert `rst`=0 while in SCAN_WAIT; the model's `drp_drdy` arrives 2 cycles after release. Expect:
  - No `smp_valid` from that late response.
  - All outputs 0 during reset.
  - The next `eos` restarts at slot 0.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared DRP constants and the scheduler state encoding for the XADC DRP scheduler.
package xadc_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [DRP_AW-1:0] ADDR_TEMP   = 7'h00;
  localparam logic [DRP_AW-1:0] ADDR_VCCINT = 7'h01;
  localparam logic [DRP_AW-1:0] ADDR_VCCAUX = 7'h02;
  localparam logic [DRP_AW-1:0] ADDR_VPVN   = 7'h03;
  localparam logic [DRP_AW-1:0] ADDR_CFG0   = 7'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_ISSUE,
    ST_SCAN_WAIT,
    ST_HOST_ISSUE,
    ST_HOST_WAIT
  } drp_state_t;

endpackage

// File: rtl/xadc_drp_scheduler_watchdog.sv
// Loadable down-counter that flags a DRP transaction whose drdy never arrives.
module drp_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cancel,
  output logic expired
);

  // Loaded on the den cycle so that expiry lands exactly TIMEOUT cycles later.
  localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

  logic [7:0] cnt;
  logic       active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= LOAD;
      active <= 1'b1;
    end else if (cancel || (active && cnt == '0)) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = active && (cnt == '0);

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Shares the XADC DRP between an eos-triggered channel scan and single host transactions.
module xadc_drp_scheduler
  import xadc_pkg::*;
#(
  parameter int unsigned               NUM_CH  = 2,
  parameter logic [NUM_CH*DRP_AW-1:0]  CH_ADDR = {ADDR_VPVN, ADDR_TEMP},
  parameter int unsigned               TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eos,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [DRP_AW-1:0] host_addr,
  input  logic [DRP_DW-1:0] host_wdata,
  output logic              host_ack,
  output logic [DRP_DW-1:0] host_rdata,
  output logic              host_err,
  output logic              smp_valid,
  output logic [3:0]        smp_idx,
  output logic [11:0]       smp_data,
  output logic              scan_done,
  output logic              overrun,
  output logic              timeout_err,
  output drp_state_t        dbg_state
);

  // Handshake: host_req is a level held until the one-cycle host_ack; the host
  // drops it the cycle after ack, and the arbiter ignores it during the ack cycle.

  drp_state_t        state, state_n;
  logic [3:0]        slot;
  logic              scan_pend, ovr_seen, last_host, host_q, txn_we;
  logic              scan_want, host_want, start0, slot_last, wd_expired;
  logic              grant_scan, grant_host, scan_ok, scan_to, host_ok, host_to;
  logic [DRP_AW-1:0] slot_addr;

  assign dbg_state = state;
  assign scan_want = scan_pend || (slot != 4'd0);
  assign host_want = host_q && !host_ack;
  assign start0    = (state == ST_SCAN_ISSUE) && (slot == 4'd0);
  assign slot_last = (slot == 4'(NUM_CH - 1));

  always_comb begin
    slot_addr = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (slot == 4'(i)) slot_addr = CH_ADDR[i*DRP_AW +: DRP_AW];
    end
  end

  drp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   ((state == ST_SCAN_ISSUE) || (state == ST_HOST_ISSUE)),
    .cancel  (scan_ok || host_ok),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // When both sides want the port, whoever was not granted last goes next.
  always_comb begin
    state_n    = state;
    grant_scan = 1'b0;
    grant_host = 1'b0;
    scan_ok    = 1'b0;
    scan_to    = 1'b0;
    host_ok    = 1'b0;
    host_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_want && (!host_want || last_host)) begin
          grant_scan = 1'b1;
          state_n    = ST_SCAN_ISSUE;
        end else if (host_want) begin
          grant_host = 1'b1;
          state_n    = ST_HOST_ISSUE;
        end
      end
      ST_SCAN_ISSUE: state_n = ST_SCAN_WAIT;
      ST_SCAN_WAIT: begin
        if (drp_drdy) begin
          scan_ok = 1'b1;
          state_n = ST_IDLE;
        end else if (wd_expired) begin
          scan_to = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_HOST_ISSUE: state_n = ST_HOST_WAIT;
      ST_HOST_WAIT: begin
        if (drp_drdy) begin
          host_ok = 1'b1;
          state_n = ST_IDLE;
        end else if (wd_expired) begin
          host_to = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot        <= '0;
      scan_pend   <= 1'b0;
      ovr_seen    <= 1'b0;
      last_host   <= 1'b1;
      host_q      <= 1'b0;
      txn_we      <= 1'b0;
      drp_daddr   <= '0;
      drp_den     <= 1'b0;
      drp_dwe     <= 1'b0;
      drp_di      <= '0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      host_err    <= 1'b0;
      smp_valid   <= 1'b0;
      smp_idx     <= '0;
      smp_data    <= '0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Registering host_req gives it the same one-cycle latency as eos.
      host_q <= host_req && !host_ack;

      // eos up to and including the slot-0 issue cycle folds into the pending scan.
      if (start0) begin
        scan_pend <= 1'b0;
        ovr_seen  <= 1'b0;
      end else if (eos) begin
        scan_pend <= 1'b1;
        if (scan_pend) ovr_seen <= 1'b1;
      end
      overrun <= eos && scan_pend && !ovr_seen;

      drp_den <= grant_scan || grant_host;
      drp_dwe <= grant_host && host_we;
      if (grant_scan) begin
        drp_daddr <= slot_addr;
      end else if (grant_host) begin
        drp_daddr <= host_addr;
        drp_di    <= host_wdata;
        txn_we    <= host_we;
      end
      if (grant_scan || grant_host) last_host <= grant_host;

      if (scan_ok || scan_to) slot <= slot_last ? 4'd0 : slot + 4'd1;
      smp_valid <= scan_ok;
      if (scan_ok) begin
        smp_idx  <= slot;
        smp_data <= drp_do[15:4];
      end
      scan_done   <= (scan_ok || scan_to) && slot_last;
      timeout_err <= scan_to;

      host_ack   <= host_ok || host_to;
      host_err   <= host_to;
      host_rdata <= (host_ok && !txn_we) ? drp_do : '0;
    end
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Self-checking bench for xadc_drp_scheduler: DRP slave model, host vector table, scan corner cases, random traffic.
module tb_xadc_drp_scheduler;
  import xadc_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 64;

  typedef struct { int cyc; logic [6:0] addr; logic we; } den_t;
  typedef struct { int cyc; logic [3:0] idx; logic [11:0] data; } smp_t;
  typedef struct {
    logic we; logic [6:0] addr; logic [15:0] wdata; int delay; bit drop;
    logic [15:0] exp_rd; logic exp_err;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0, eos = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0;
  logic        drp_drdy = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = 7'h0;
  logic [15:0] host_wdata = 16'h0;
  logic        host_ack, host_err, smp_valid, scan_done, overrun, timeout_err;
  logic [15:0] host_rdata;
  logic [3:0]  smp_idx;
  logic [11:0] smp_data;
  drp_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // DRP slave model state
  logic [15:0] mem [0:127];
  logic [15:0] ref_mem [0:127];
  int          resp_delay = 3;
  bit          rand_delay = 1'b0, drop_all = 1'b0, drop_a_en = 1'b0;
  logic [6:0]  drop_a = 7'h0;
  logic [6:0]  ch_list [NUM_CH] = '{ADDR_TEMP, ADDR_VPVN};

  den_t den_log[$];
  smp_t smp_log[$];
  int   done_log[$];
  int   to_log[$];
  int   ovr_log[$];
  logic [15:0] exp_q[$];
  vec_t vecs[8];

  xadc_drp_scheduler #(
    .NUM_CH(NUM_CH), .CH_ADDR({ADDR_VPVN, ADDR_TEMP}), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .eos(eos),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .smp_valid(smp_valid), .smp_idx(smp_idx), .smp_data(smp_data),
    .scan_done(scan_done), .overrun(overrun), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- DRP slave: answers den after a delay unless dropped ----------------
  initial begin : drp_slave
    logic [6:0]  r_a;
    logic        r_we;
    logic [15:0] r_di;
    int          r_d;
    forever begin
      @(posedge clk); #1;
      if (drp_den) begin
        r_a = drp_daddr; r_we = drp_dwe; r_di = drp_di;
        r_d = rand_delay ? int'($urandom_range(8, 1)) : resp_delay;
        if (!(drop_all || (drop_a_en && r_a == drop_a))) begin
          repeat (r_d) @(posedge clk);
          #1;
          if (r_we) mem[r_a] = r_di;
          drp_do   = r_we ? 16'hDEAD : mem[r_a];
          drp_drdy = 1'b1;
          @(posedge clk); #1;
          drp_drdy = 1'b0;
          drp_do   = 16'h0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (drp_den)     den_log.push_back('{cyc, drp_daddr, drp_dwe});
    if (smp_valid)   smp_log.push_back('{cyc, smp_idx, smp_data});
    if (scan_done)   done_log.push_back(cyc);
    if (timeout_err) to_log.push_back(cyc);
    if (overrun)     ovr_log.push_back(cyc);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expire(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_outputs_zero", 64'({drp_daddr, drp_den, drp_dwe, drp_di, host_ack, host_rdata,
          host_err, smp_valid, smp_idx, smp_data, scan_done, overrun, timeout_err}), 64'h0);
    check("rst_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_log.size() < target && n < budget) begin tick(); n++; end
    if (done_log.size() < target) expire(name, "scan_done did not arrive in budget");
  endtask

  task automatic wait_den(input int budget, input string name);
    int n;
    n = 0;
    while (!drp_den && n < budget) begin tick(); n++; end
    if (!drp_den) expire(name, "drp_den did not arrive in budget");
  endtask

  task automatic pulse_eos(input int len);
    eos = 1'b1;
    repeat (len) tick();
    eos = 1'b0;
  endtask

  task automatic host_txn(input string name, input logic we, input logic [6:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_err);
    int n;
    host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!host_ack && n < 400);
    if (!host_ack) expire(name, "host_ack did not arrive in budget");
    else begin
      check({name, "_rdata"}, 64'(host_rdata), 64'(exp_rd));
      check({name, "_err"}, 64'(host_err), 64'(exp_err));
    end
    tick();
    host_req = 1'b0;
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic test_single();
    int md, ms, mc, c0;
    do_reset();
    resp_delay = 3; mem[ADDR_TEMP] = 16'hABC0; mem[ADDR_VPVN] = 16'h1230;
    md = den_log.size(); ms = smp_log.size(); mc = done_log.size();
    c0 = cyc;
    pulse_eos(1);
    wait_done(mc + 1, 300, "single_wait");
    repeat (5) tick();
    check("single_den_count", 64'(den_log.size() - md), 64'd2);
    if (den_log.size() - md == 2) begin
      check("single_addr0", 64'(den_log[md].addr), 64'(ADDR_TEMP));
      check("single_eos_to_den", 64'(den_log[md].cyc), 64'(c0 + 2));
      check("single_addr1", 64'(den_log[md+1].addr), 64'(ADDR_VPVN));
      check("single_drdy_to_den", 64'(den_log[md+1].cyc - den_log[md].cyc), 64'd5);
    end
    check("single_smp_count", 64'(smp_log.size() - ms), 64'd2);
    if (smp_log.size() - ms == 2 && den_log.size() - md == 2) begin
      check("single_smp0", 64'({smp_log[ms].idx, smp_log[ms].data}), 64'({4'd0, 12'hABC}));
      check("single_smp1", 64'({smp_log[ms+1].idx, smp_log[ms+1].data}), 64'({4'd1, 12'h123}));
      check("single_drdy_to_valid", 64'(smp_log[ms].cyc - den_log[md].cyc), 64'd4);
      if (done_log.size() > mc)
        check("single_done_with_last", 64'(done_log[mc]), 64'(smp_log[ms+1].cyc));
    end
  endtask

  task automatic test_contention();
    int md;
    do_reset();
    resp_delay = 3; mem[ADDR_CFG0] = 16'h7E57;
    md = den_log.size();
    fork
      pulse_eos(1);
      host_txn("contend_host", 1'b0, ADDR_CFG0, 16'h0, 16'h7E57, 1'b0);
    join
    repeat (20) tick();
    check("contend_den_count", 64'(den_log.size() - md), 64'd3);
    if (den_log.size() - md == 3) begin
      check("contend_order0", 64'(den_log[md].addr), 64'(ADDR_TEMP));
      check("contend_order1", 64'({den_log[md+1].we, den_log[md+1].addr}), 64'({1'b0, ADDR_CFG0}));
      check("contend_order2", 64'(den_log[md+2].addr), 64'(ADDR_VPVN));
    end
  endtask

  task automatic test_overrun();
    int md, ms, mc, mo;
    do_reset();
    resp_delay = 3;
    md = den_log.size(); mc = done_log.size(); mo = ovr_log.size();
    pulse_eos(3);
    wait_done(mc + 1, 300, "ovr_wait");
    repeat (20) tick();
    check("ovr3_scans", 64'(done_log.size() - mc), 64'd1);
    check("ovr3_pulses", 64'(ovr_log.size() - mo), 64'd1);
    check("ovr3_dens", 64'(den_log.size() - md), 64'd2);
    md = den_log.size(); ms = smp_log.size(); mc = done_log.size(); mo = ovr_log.size();
    pulse_eos(1);
    wait_den(20, "midscan_den");
    tick();
    pulse_eos(1);
    wait_done(mc + 2, 400, "midscan_wait");
    repeat (20) tick();
    check("midscan_scans", 64'(done_log.size() - mc), 64'd2);
    check("midscan_dens", 64'(den_log.size() - md), 64'd4);
    check("midscan_samples", 64'(smp_log.size() - ms), 64'd4);
    check("midscan_no_overrun", 64'(ovr_log.size() - mo), 64'd0);
    if (den_log.size() - md == 4)
      check("midscan_restart_slot0", 64'(den_log[md+2].addr), 64'(ADDR_TEMP));
  endtask

  task automatic test_timeout();
    int md, ms, mc, mt;
    do_reset();
    resp_delay = 3; drop_a_en = 1'b1; drop_a = ADDR_VPVN; mem[ADDR_TEMP] = 16'h4440;
    md = den_log.size(); ms = smp_log.size(); mc = done_log.size(); mt = to_log.size();
    pulse_eos(1);
    wait_done(mc + 1, 300, "to_wait");
    repeat (5) tick();
    check("to_pulses", 64'(to_log.size() - mt), 64'd1);
    check("to_samples", 64'(smp_log.size() - ms), 64'd1);
    if (smp_log.size() - ms == 1)
      check("to_sample_slot0", 64'({smp_log[ms].idx, smp_log[ms].data}), 64'({4'd0, 12'h444}));
    if (to_log.size() - mt == 1 && den_log.size() - md == 2) begin
      check("to_latency", 64'(to_log[mt] - den_log[md+1].cyc), 64'(TIMEOUT + 1));
      if (done_log.size() > mc) check("to_done_same_cycle", 64'(done_log[mc]), 64'(to_log[mt]));
    end
    drop_a_en = 1'b0; drop_all = 1'b1;
    host_txn("to_host_write", 1'b1, ADDR_CFG0, 16'h1111, 16'h0, 1'b1);
    drop_all = 1'b0;
  endtask

  task automatic test_reset_midscan();
    int ms, md, mc;
    do_reset();
    resp_delay = 7;
    pulse_eos(1);
    wait_den(20, "rstmid_den");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_outputs_zero", 64'({drp_daddr, drp_den, drp_dwe, drp_di, host_ack, host_rdata,
          host_err, smp_valid, smp_idx, smp_data, scan_done, overrun, timeout_err}), 64'h0);
    ms = smp_log.size();
    rst = 1'b1;
    repeat (15) tick();
    check("rstmid_late_drdy_ignored", 64'(smp_log.size() - ms), 64'd0);
    resp_delay = 3;
    md = den_log.size(); ms = smp_log.size(); mc = done_log.size();
    pulse_eos(1);
    wait_done(mc + 1, 300, "rstmid_wait");
    if (den_log.size() > md) check("rstmid_restart_addr", 64'(den_log[md].addr), 64'(ADDR_TEMP));
    if (smp_log.size() > ms) check("rstmid_restart_idx", 64'(smp_log[ms].idx), 64'd0);
  endtask

  // ---------------- randomized traffic vs. memory reference model ----------------
  task automatic test_random();
    int ms, md, mc, mo, mt, h;
    bit in_scan;
    do_reset();
    for (int a = 0; a < 128; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    rand_delay = 1'b1;
    ms = smp_log.size(); md = den_log.size(); mc = done_log.size();
    mo = ovr_log.size(); mt = to_log.size();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(30, 0)) tick();
          for (int s = 0; s < NUM_CH; s++) exp_q.push_back({4'(s), ref_mem[ch_list[s]][15:4]});
          pulse_eos(1);
          wait_done(mc + k + 1, 600, "rand_scan_wait");
        end
      end
      begin
        for (int t = 0; t < 20; t++) begin
          logic       we;
          logic [6:0] a;
          logic [15:0] wd;
          repeat ($urandom_range(6, 0)) tick();
          we = 1'($urandom_range(1, 0));
          a  = 7'h40 + 7'($urandom_range(15, 0));
          wd = 16'($urandom);
          host_txn($sformatf("rand_host%0d", t), we, a, wd, we ? 16'h0 : ref_mem[a], 1'b0);
          if (we) ref_mem[a] = wd;
        end
      end
    join
    repeat (20) tick();
    rand_delay = 1'b0;
    check("rand_sample_count", 64'(smp_log.size() - ms), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && ms + i < smp_log.size(); i++)
      check($sformatf("rand_sample%0d", i),
            64'({smp_log[ms+i].idx, smp_log[ms+i].data}), 64'(exp_q[i]));
    check("rand_no_overrun", 64'(ovr_log.size() - mo), 64'd0);
    check("rand_no_timeout", 64'(to_log.size() - mt), 64'd0);
    in_scan = 1'b0; h = 0;
    for (int i = md; i < den_log.size(); i++) begin
      if (den_log[i].addr == ADDR_TEMP) begin in_scan = 1'b1; h = 0; end
      else if (den_log[i].addr == ADDR_VPVN && in_scan) begin
        check("rand_one_host_between_slots", 64'(h <= 1), 64'd1);
        in_scan = 1'b0;
      end else if (in_scan) h++;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 16'h0;
    vecs[0] = '{1'b1, 7'h41, 16'h1234, 1,  1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 7'h41, 16'h0000, 2,  1'b0, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 7'h40, 16'h0000, 5,  1'b0, 16'h5A5A, 1'b0};
    vecs[3] = '{1'b1, 7'h42, 16'hBEEF, 64, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 7'h42, 16'h0000, 64, 1'b0, 16'hBEEF, 1'b0};
    vecs[5] = '{1'b0, 7'h43, 16'h0000, 3,  1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 7'h44, 16'h0000, 65, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{1'b0, 7'h02, 16'h0000, 1,  1'b0, 16'h0F0F, 1'b0};

    do_reset();
    mem[7'h40] = 16'h5A5A; mem[7'h44] = 16'h9999; mem[7'h02] = 16'h0F0F;
    for (int i = 0; i < 8; i++) begin
      resp_delay = vecs[i].delay;
      drop_all   = vecs[i].drop;
      host_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rd, vecs[i].exp_err);
      drop_all = 1'b0;
      repeat (3) tick();
    end

    test_single();
    test_contention();
    test_overrun();
    test_timeout();
    test_reset_midscan();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
